bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD up/down score counter for the scoreboard datapath. It replaces the fixed 2-digit, step-of-1 counter with a configurable digit count, a step size, synchronous load, and wrap or saturate modes. Overflow and underflow are reported with sticky flags. It sits between the debounced button/command logic and the seven-segment display drivers.

## Interface
- DIGITS, 2, number of BCD digits (legal 1..8); counter range 0 .. 10^DIGITS−1.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- clear  input  1  synchronous clear of count and sticky flags.
- load  input  1  synchronous load of load_value.
- load_value  input  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
- increment  input  1  add step.
- decrement  input  1  subtract step.
- step  input  4  step amount, binary 0..9; values 10..15 are treated as 9; 0 means no count change.
- wrap  input  1  1 = modulo 10^DIGITS, 0 = saturate at 0 / maximum.
- bcd  output  4*DIGITS  registered count; digit 0 (least significant) in bits [3:0].
- at_zero  output  1  high while bcd == 0.
- at_max  output  1  high while every digit == 9.
- overflow  output  1  sticky; set by an increment that exceeds the maximum.
- underflow  output  1  sticky; set by a decrement that goes below 0.

## Operation
- Command priority, evaluated per cycle: reset > clear > load > (inc and dec together) > inc > dec > hold.
- clear: bcd=0, overflow=0, underflow=0.
- load: bcd=load_value, with each digit >9 replaced by 9; overflow=0, underflow=0.
- inc and dec active in the same cycle: bcd, overflow and underflow all hold.
- Increment, with v = current value and s = effective step:
  - If v+s ≤ max, bcd=v+s.
  - Otherwise, with wrap=1, bcd=v+s−10^DIGITS; with wrap=0, bcd=max.
  - In both overflow cases, overflow is set.
- Decrement:
  - If v ≥ s, bcd=v−s.
  - Otherwise, with wrap=1, bcd=v−s+10^DIGITS; with wrap=0, bcd=0.
  - In both underflow cases, underflow is set.
- Arithmetic is digit-serial BCD add/subtract with decimal carry/borrow rippling across all DIGITS within one cycle. Every digit of bcd must always be 0..9.
- step=0 with inc or dec: bcd unchanged and no flag set; this counts as an accepted command.
- Sticky flags clear only on reset, clear or load. Once set, they hold through further counting.
- at_zero and at_max are decoded from the bcd register only (no input paths).

## Timing
- Reset values: bcd=0, overflow=0, underflow=0, at_zero=1, at_max=0, edge-history registers=0.
- reset is asynchronous assert. It is released synchronously by upstream logic; the block itself needs no synchronous release.
- Latency is 1 cycle: a command sampled at edge N is visible on bcd and the flags after edge N.
- One count operation per accepted command event; no multi-cycle operations and no busy state.
- Reset asserted between edges forces all outputs to their reset values immediately. In-flight commands are discarded.
- The wrap input is sampled in the same cycle as the command and may change every cycle.

## Configuration
- Macro BCD_CNT_EDGE_DETECT_EN.
- Defined:
  - increment and decrement are each registered; a command event fires only on a 0→1 transition (current=1, previous sample=0).
  - A held input counts once. After reset, an input already high at the first edge counts once.
  - The simultaneity rule applies to the detected events, not to the levels.
  - clear and load remain level-sensitive.
- Undefined: increment and decrement are level-sensitive; the counter steps on every cycle the input is high. There are no history registers.

## Test plan
- Reset, then load 8'h98 (DIGITS=2), wrap=0, step=3, one increment -> bcd=8'h99, overflow=1, at_max=1. A further decrement with step=9 -> bcd=8'h90, overflow stays 1.
- Load 8'h05, wrap=1, step=7, one decrement -> bcd=8'h98, underflow=1. Then clear -> bcd=0, both flags 0, at_zero=1.
- Load 8'h3C -> bcd=8'h39. Load 8'h19, step=1, increment -> bcd=8'h20 (decimal carry).
- bcd=8'h42 with increment and decrement both high for 3 cycles -> bcd stays 8'h42 and the flags are unchanged.
- With BCD_CNT_EDGE_DETECT_EN defined, increment held high 10 cycles with step=1 from 0 -> bcd=8'h01. Without the macro -> bcd=8'h10.
- Assert reset mid-sequence between clock edges -> bcd=0 and flags 0 before the next edge. step=12 increment from 0 -> bcd=8'h09.

Source files
------------

// File: rtl/bcd_updown_counter_if.sv
// Command/status bundle for bcd_updown_counter: the master drives commands, the counter reports count and flags.
interface bcd_updown_counter_if #(
   parameter int DIGITS = 2
);
   logic                  clear;
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic                  increment;
   logic                  decrement;
   logic [3:0]            step;
   logic                  wrap;
   logic [4*DIGITS-1:0]   bcd;
   logic                  at_zero;
   logic                  at_max;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clear, load, load_value, increment, decrement, step, wrap,
      input  bcd, at_zero, at_max, overflow, underflow
   );

   modport slave (
      input  clear, load, load_value, increment, decrement, step, wrap,
      output bcd, at_zero, at_max, overflow, underflow
   );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down score counter with step, load, wrap/saturate and sticky over/underflow flags.
// Define BCD_CNT_EDGE_DETECT_EN to count on rising edges of increment/decrement instead of levels.
module bcd_updown_counter #(
   parameter int DIGITS = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   bcd_updown_counter_if.slave    bus_if
);
   localparam logic [4*DIGITS-1:0] MAX_V = {DIGITS{4'h9}};

   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                inc_evt, dec_evt;
   logic [3:0]          step_eff;
   logic [4*DIGITS-1:0] load_sat;
   logic [4*DIGITS-1:0] sum_v, dif_v;
   logic [DIGITS:0]     cy_add, br_sub;

`ifdef BCD_CNT_EDGE_DETECT_EN
   logic inc_hist_q, dec_hist_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_hist_q <= 1'b0;
         dec_hist_q <= 1'b0;
      end else begin
         inc_hist_q <= bus_if.increment;
         dec_hist_q <= bus_if.decrement;
      end
   end

   assign inc_evt = bus_if.increment & ~inc_hist_q;
   assign dec_evt = bus_if.decrement & ~dec_hist_q;
`else
   assign inc_evt = bus_if.increment;
   assign dec_evt = bus_if.decrement;
`endif

   assign step_eff  = (bus_if.step > 4'd9) ? 4'd9 : bus_if.step;
   assign cy_add[0] = 1'b0;
   assign br_sub[0] = 1'b0;

   // Step enters at digit 0; decimal carry/borrow ripples through the rest.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] addend;
      logic [4:0] s_raw;
      logic [4:0] d_raw;
      logic [3:0] ld_digit;

      assign digit  = bcd_q[4*g +: 4];
      assign addend = (g == 0) ? step_eff : 4'd0;

      assign s_raw          = {1'b0, digit} + {1'b0, addend} + {4'd0, cy_add[g]};
      assign cy_add[g+1]    = (s_raw > 5'd9);
      assign sum_v[4*g +: 4] = cy_add[g+1] ? 4'(s_raw - 5'd10) : s_raw[3:0];

      assign d_raw          = {1'b0, digit} - {1'b0, addend} - {4'd0, br_sub[g]};
      assign br_sub[g+1]    = d_raw[4];
      assign dif_v[4*g +: 4] = br_sub[g+1] ? 4'(d_raw + 5'd10) : d_raw[3:0];

      assign ld_digit          = bus_if.load_value[4*g +: 4];
      assign load_sat[4*g +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
   end

   always_comb begin
      bcd_d = bcd_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (bus_if.clear) begin
         bcd_d = '0;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (bus_if.load) begin
         bcd_d = load_sat;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (inc_evt && !dec_evt) begin
         if (cy_add[DIGITS]) begin
            ovf_d = 1'b1;
            bcd_d = bus_if.wrap ? sum_v : MAX_V;
         end else begin
            bcd_d = sum_v;
         end
      end else if (dec_evt && !inc_evt) begin
         if (br_sub[DIGITS]) begin
            unf_d = 1'b1;
            bcd_d = bus_if.wrap ? dif_v : '0;
         end else begin
            bcd_d = dif_v;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcd_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         bcd_q <= bcd_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus_if.bcd       = bcd_q;
   assign bus_if.overflow  = ovf_q;
   assign bus_if.underflow = unf_q;
   assign bus_if.at_zero   = (bcd_q == '0);
   assign bus_if.at_max    = (bcd_q == MAX_V);
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter (DIGITS=2), expectations hand-computed in decimal.
module tb_bcd_updown_counter;
   localparam int DIGITS = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   bcd_updown_counter_if #(.DIGITS(DIGITS)) cnt_if ();

   bcd_updown_counter #(.DIGITS(DIGITS)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_if (cnt_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [7:0] exp_bcd,
                              input logic exp_ov, input logic exp_un);
      check_eq({tag, ".bcd"}, 32'(cnt_if.bcd), 32'(exp_bcd));
      check_eq({tag, ".ovf"}, 32'(cnt_if.overflow), 32'(exp_ov));
      check_eq({tag, ".unf"}, 32'(cnt_if.underflow), 32'(exp_un));
   endtask

   task automatic do_load(input logic [7:0] v);
      cnt_if.load_value = v;
      cnt_if.load       = 1'b1;
      tick();
      cnt_if.load       = 1'b0;
      tick();
   endtask

   task automatic do_count(input logic inc, input logic dec, input logic [3:0] s, input logic w);
      cnt_if.increment = inc;
      cnt_if.decrement = dec;
      cnt_if.step      = s;
      cnt_if.wrap      = w;
      tick();
      cnt_if.increment = 1'b0;
      cnt_if.decrement = 1'b0;
      tick();
   endtask

   task automatic do_clear();
      cnt_if.clear = 1'b1;
      tick();
      cnt_if.clear = 1'b0;
      tick();
   endtask

   initial begin
      reset            = 1'b1;
      cnt_if.clear      = 1'b0;
      cnt_if.load       = 1'b0;
      cnt_if.load_value = '0;
      cnt_if.increment  = 1'b0;
      cnt_if.decrement  = 1'b0;
      cnt_if.step       = 4'd1;
      cnt_if.wrap       = 1'b0;
      #12;
      check_state("rst", 8'h00, 1'b0, 1'b0);
      check_eq("rst.at_zero", 32'(cnt_if.at_zero), 32'd1);
      check_eq("rst.at_max", 32'(cnt_if.at_max), 32'd0);
      reset = 1'b0;
      tick();

      do_load(8'h98);
      check_state("load98", 8'h98, 1'b0, 1'b0);
      do_count(1'b1, 1'b0, 4'd3, 1'b0);
      check_state("sat_inc", 8'h99, 1'b1, 1'b0);
      check_eq("sat_inc.at_max", 32'(cnt_if.at_max), 32'd1);
      do_count(1'b0, 1'b1, 4'd9, 1'b0);
      check_state("dec9_sticky", 8'h90, 1'b1, 1'b0);

      do_load(8'h05);
      check_state("load05", 8'h05, 1'b0, 1'b0);
      do_count(1'b0, 1'b1, 4'd7, 1'b1);
      check_state("wrap_dec", 8'h98, 1'b0, 1'b1);
      do_clear();
      check_state("clear", 8'h00, 1'b0, 1'b0);
      check_eq("clear.at_zero", 32'(cnt_if.at_zero), 32'd1);

      do_load(8'h3C);
      check_state("load3C", 8'h39, 1'b0, 1'b0);
      do_load(8'hF7);
      check_state("loadF7", 8'h97, 1'b0, 1'b0);
      do_load(8'h19);
      do_count(1'b1, 1'b0, 4'd1, 1'b0);
      check_state("carry", 8'h20, 1'b0, 1'b0);
      do_count(1'b0, 1'b1, 4'd1, 1'b0);
      check_state("borrow", 8'h19, 1'b0, 1'b0);

      do_load(8'h95);
      do_count(1'b1, 1'b0, 4'd9, 1'b1);
      check_state("wrap_inc", 8'h04, 1'b1, 1'b0);
      cnt_if.increment = 1'b1;
      cnt_if.decrement = 1'b1;
      repeat (3) tick();
      cnt_if.increment = 1'b0;
      cnt_if.decrement = 1'b0;
      tick();
      check_state("both_flag", 8'h04, 1'b1, 1'b0);

      do_load(8'h42);
      cnt_if.increment = 1'b1;
      cnt_if.decrement = 1'b1;
      repeat (3) tick();
      cnt_if.increment = 1'b0;
      cnt_if.decrement = 1'b0;
      tick();
      check_state("both42", 8'h42, 1'b0, 1'b0);
      do_count(1'b1, 1'b0, 4'd0, 1'b0);
      check_state("step0_inc", 8'h42, 1'b0, 1'b0);
      do_count(1'b0, 1'b1, 4'd0, 1'b0);
      check_state("step0_dec", 8'h42, 1'b0, 1'b0);

      do_load(8'h03);
      do_count(1'b0, 1'b1, 4'd5, 1'b0);
      check_state("sat_dec", 8'h00, 1'b0, 1'b1);
      check_eq("sat_dec.at_zero", 32'(cnt_if.at_zero), 32'd1);

      do_clear();
      do_count(1'b1, 1'b0, 4'd12, 1'b0);
      check_state("step12", 8'h09, 1'b0, 1'b0);

      do_clear();
      cnt_if.step      = 4'd1;
      cnt_if.increment = 1'b1;
      repeat (10) tick();
      cnt_if.increment = 1'b0;
      tick();
`ifdef BCD_CNT_EDGE_DETECT_EN
      check_state("held10", 8'h01, 1'b0, 1'b0);
`else
      check_state("held10", 8'h10, 1'b0, 1'b0);
`endif

      do_load(8'h99);
      do_count(1'b1, 1'b0, 4'd1, 1'b1);
      check_state("wrap99", 8'h00, 1'b1, 1'b0);
      do_count(1'b1, 1'b0, 4'd5, 1'b1);
      check_state("pre_rst", 8'h05, 1'b1, 1'b0);

      cnt_if.increment = 1'b1;
      cnt_if.step      = 4'd1;
      cnt_if.wrap      = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_state("async_rst", 8'h00, 1'b0, 1'b0);
      check_eq("async_rst.at_zero", 32'(cnt_if.at_zero), 32'd1);
      reset = 1'b0;
      tick();
      check_state("first_edge", 8'h01, 1'b0, 1'b0);
      tick();
`ifdef BCD_CNT_EDGE_DETECT_EN
      check_state("second_edge", 8'h01, 1'b0, 1'b0);
`else
      check_state("second_edge", 8'h02, 1'b0, 1'b0);
`endif
      cnt_if.increment = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
